// File: rtl/sobel_frame_scheduler.sv
// Frame-level sequencer around the Sobel read/write core and its two BRAMs.
// A frame is: accept one command, load N pixels into BRAM0, start the core
// (MOVE or RUN), wait for done, then drain M pixels from BRAM1 as a stream.
// Optional PROC watchdog: define SOBEL_SCHED_TIMEOUT_EN.
module sobel_frame_scheduler #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_run,
    input  logic [ADDR_WIDTH-1:0] cmd_num_cnt,
    input  logic [ADDR_WIDTH-1:0] cmd_out_cnt,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  core_en,
    output logic                  core_run,
    output logic [ADDR_WIDTH-1:0] core_num_cnt,
    input  logic                  core_idle,
    input  logic                  core_done,
    output logic                  b0_ce0,
    output logic                  b0_we0,
    output logic [ADDR_WIDTH-1:0] b0_addr0,
    output logic [DATA_WIDTH-1:0] b0_d0,
    output logic                  b1_ce0,
    output logic                  b1_we0,
    output logic [ADDR_WIDTH-1:0] b1_addr0,
    input  logic [DATA_WIDTH-1:0] b1_q0,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic [15:0]           frame_cnt,
    output logic                  err
);

    localparam int unsigned FRAME_W = 16;
    localparam int unsigned OCC_W   = 3;

    // The watchdog counter is 16 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..65535");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_PROC,
        S_DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic                  run_q;
    logic [ADDR_WIDTH-1:0] nm1_q;
    logic [ADDR_WIDTH-1:0] mm1_q;
    logic [ADDR_WIDTH-1:0] load_addr_q;
    logic [ADDR_WIDTH-1:0] rd_cnt_q;
    logic [ADDR_WIDTH-1:0] out_cnt_q;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] fifo_mem_q [2];
    logic                  fifo_wr_q;
    logic                  fifo_rd_q;
    logic [1:0]            fifo_cnt_q;
    logic [FRAME_W-1:0]    frame_cnt_q;
    logic                  cmd_ready_q;
    logic                  err_q;

    logic                  accept;
    logic                  cmd_ok;
    logic                  pop;
    logic                  drain_done;
    logic                  rd_issue;
    logic [OCC_W-1:0]      occ;
    logic                  core_phase;

`ifdef SOBEL_SCHED_TIMEOUT_EN
    localparam int unsigned WD_W = 16;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_q;
    logic            wd_expire;
`endif

    assign accept     = (state_q == S_IDLE) && cmd_valid && cmd_ready_q;
    assign cmd_ok     = (cmd_num_cnt != '0) && (cmd_out_cnt != '0);
    assign m_valid    = (state_q == S_DRAIN) && (fifo_cnt_q != 2'd0);
    assign pop        = m_valid && m_ready;
    assign drain_done = pop && (out_cnt_q == mm1_q);
    // Skid occupancy after this cycle, counting the read already in flight.
    assign occ        = OCC_W'(fifo_cnt_q) + OCC_W'(inflight_q) - OCC_W'(pop);
    assign rd_issue   = (state_q == S_DRAIN) && (rd_cnt_q <= mm1_q) && (occ < OCC_W'(2));
    assign core_phase = (state_q == S_START) || (state_q == S_PROC);

    assign cmd_ready    = cmd_ready_q;
    assign busy         = (state_q != S_IDLE);
    assign core_run     = core_phase && run_q;
    assign core_num_cnt = core_phase ? nm1_q : '0;
    assign b1_we0       = 1'b0;
    assign m_data       = m_valid ? fifo_mem_q[fifo_rd_q] : '0;
    assign m_last       = m_valid && (out_cnt_q == mm1_q);
    assign frame_cnt    = frame_cnt_q;
    assign err          = err_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state port strobes.
    always_comb begin
        state_d  = state_q;
        s_ready  = 1'b0;
        core_en  = 1'b0;
        b0_ce0   = 1'b0;
        b0_we0   = 1'b0;
        b0_addr0 = '0;
        b0_d0    = '0;
        b1_ce0   = 1'b0;
        b1_addr0 = '0;
`ifdef SOBEL_SCHED_TIMEOUT_EN
        wd_expire = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (accept && cmd_ok) state_d = S_LOAD;
            end
            S_LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    b0_ce0   = 1'b1;
                    b0_we0   = 1'b1;
                    b0_addr0 = load_addr_q;
                    b0_d0    = s_data;
                    if (load_addr_q == nm1_q) state_d = S_START;
                end
            end
            S_START: begin
                if (core_idle) begin
                    core_en = 1'b1;
                    state_d = S_PROC;
                end
            end
            S_PROC: begin
                if (core_done) state_d = S_DRAIN;
`ifdef SOBEL_SCHED_TIMEOUT_EN
                else if (wd_q == WD_LAST) begin
                    wd_expire = 1'b1;
                    state_d   = S_IDLE;
                end
`endif
            end
            S_DRAIN: begin
                if (rd_issue) begin
                    b1_ce0   = 1'b1;
                    b1_addr0 = rd_cnt_q;
                end
                if (drain_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Command latch, load address, drain counters and output skid buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q         <= 1'b0;
            nm1_q         <= '0;
            mm1_q         <= '0;
            load_addr_q   <= '0;
            rd_cnt_q      <= '0;
            out_cnt_q     <= '0;
            inflight_q    <= 1'b0;
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            fifo_wr_q     <= 1'b0;
            fifo_rd_q     <= 1'b0;
            fifo_cnt_q    <= 2'd0;
        end else begin
            if (accept && cmd_ok) begin
                run_q       <= cmd_run;
                nm1_q       <= cmd_num_cnt - ADDR_WIDTH'(1);
                mm1_q       <= cmd_out_cnt - ADDR_WIDTH'(1);
                load_addr_q <= '0;
            end
            if (b0_ce0) load_addr_q <= load_addr_q + ADDR_WIDTH'(1);

            if ((state_q == S_PROC) && core_done) begin
                rd_cnt_q   <= '0;
                out_cnt_q  <= '0;
                inflight_q <= 1'b0;
                fifo_wr_q  <= 1'b0;
                fifo_rd_q  <= 1'b0;
                fifo_cnt_q <= 2'd0;
            end else if (state_q == S_DRAIN) begin
                inflight_q <= rd_issue;
                if (rd_issue) rd_cnt_q <= rd_cnt_q + ADDR_WIDTH'(1);
                if (inflight_q) begin
                    fifo_mem_q[fifo_wr_q] <= b1_q0;
                    fifo_wr_q             <= ~fifo_wr_q;
                end
                if (pop) begin
                    fifo_rd_q <= ~fifo_rd_q;
                    out_cnt_q <= out_cnt_q + ADDR_WIDTH'(1);
                end
                fifo_cnt_q <= fifo_cnt_q + 2'(inflight_q) - 2'(pop);
            end else begin
                inflight_q <= 1'b0;
            end
        end
    end

    // Command handshake, frame counter and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready_q <= 1'b0;
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            cmd_ready_q <= (state_d == S_IDLE);
            if (drain_done) frame_cnt_q <= frame_cnt_q + FRAME_W'(1);
`ifdef SOBEL_SCHED_TIMEOUT_EN
            if (wd_expire) err_q <= 1'b1;
`endif
        end
    end

`ifdef SOBEL_SCHED_TIMEOUT_EN
    // Watchdog: cycles spent in PROC for the current frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else if (state_q == S_PROC) begin
            wd_q <= wd_q + WD_W'(1);
        end else begin
            wd_q <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_sobel_frame_scheduler.sv
// Self-checking bench for sobel_frame_scheduler: random frames against a
// behavioural frame model (pixel arrays, stand-in core, BRAM models).
`timescale 1ns/1ps
module tb_sobel_frame_scheduler;

    localparam int unsigned DW   = 8;
    localparam int unsigned AW   = 14;
    localparam int unsigned MAXN = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid, cmd_ready, cmd_run;
    logic [AW-1:0] cmd_num_cnt, cmd_out_cnt;
    logic          s_valid, s_ready;
    logic [DW-1:0] s_data;
    logic          core_en, core_run, core_idle, core_done;
    logic [AW-1:0] core_num_cnt;
    logic          b0_ce0, b0_we0, b1_ce0, b1_we0;
    logic [AW-1:0] b0_addr0, b1_addr0;
    logic [DW-1:0] b0_d0;
    logic [DW-1:0] b1_q0 = '0;
    logic          m_valid, m_ready, m_last;
    logic [DW-1:0] m_data;
    logic          busy, err;
    logic [15:0]   frame_cnt;

    sobel_frame_scheduler #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_run(cmd_run),
        .cmd_num_cnt(cmd_num_cnt), .cmd_out_cnt(cmd_out_cnt),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .core_en(core_en), .core_run(core_run), .core_num_cnt(core_num_cnt),
        .core_idle(core_idle), .core_done(core_done),
        .b0_ce0(b0_ce0), .b0_we0(b0_we0), .b0_addr0(b0_addr0), .b0_d0(b0_d0),
        .b1_ce0(b1_ce0), .b1_we0(b1_we0), .b1_addr0(b1_addr0), .b1_q0(b1_q0),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .frame_cnt(frame_cnt), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Frame model state.
    logic [DW-1:0] in_data  [MAXN];
    logic [DW-1:0] exp_data [MAXN];
    logic [DW-1:0] bram0    [MAXN];
    logic [DW-1:0] bram1    [MAXN];
    int  s_idx = 0, s_total = 0, wr_idx = 0, out_idx = 0, pulses = 0;
    bit  s_gaps = 0, r_rand = 0;
    bit  ld_run = 0;
    int  ld_n = 1, ld_m = 1, cur_m = 1;
    int  exp_frames = 0;
    int  cyc = 0, first_cyc = 0, last_cyc = 0;
    bit  seen_first = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Stand-in for the Sobel kernel in RUN mode: any fixed pixel map will do.
    function automatic logic [DW-1:0] xform(input logic [DW-1:0] x);
        return DW'((x * 3) ^ 8'h5A);
    endfunction

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    // BRAM models.
    always @(posedge clk) if (b0_ce0 && b0_we0) bram0[b0_addr0] <= b0_d0;
    always @(posedge clk) if (b1_ce0) b1_q0 <= bram1[b1_addr0];

    // Input stream source.
    initial begin : s_drv
        bit acc;
        s_valid = 1'b0;
        s_data  = '0;
        forever begin
            @(negedge clk);
            acc = s_valid && s_ready && rst_n;
            @(posedge clk);
            #1;
            if (acc) s_idx++;
            if (s_idx < s_total && (!s_gaps || $urandom_range(0, 1) == 1)) begin
                s_valid = 1'b1;
                s_data  = in_data[s_idx];
            end else begin
                s_valid = 1'b0;
                s_data  = '0;
            end
        end
    end

    // Output sink backpressure.
    initial begin : m_drv
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_ready = r_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Core model: after a start pulse, fill BRAM1 from BRAM0 and pulse done.
    initial begin : core_mdl
        int dly;
        core_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && core_en) begin
                dly = $urandom_range(1, 6);
                repeat (dly) begin
                    @(negedge clk);
                    check("core_run_held", core_run, ld_run);
                    check("core_num_held", core_num_cnt, ld_n - 1);
                end
                for (int i = 0; i < ld_n; i++)
                    bram1[i] = ld_run ? xform(bram0[i]) : bram0[i];
                @(posedge clk); #1; core_done = 1'b1;
                @(posedge clk); #1; core_done = 1'b0;
            end
        end
    end

    // Port monitor: BRAM0 writes, core start, output beats.
    initial begin : mon
        bit prev_stall = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_stall = 0;
            end else begin
                if (b1_ce0) begin
                    check("b1_we0", b1_we0, 0);
                    check("b1_excl_b0", b0_ce0, 0);
                end
                if (b0_ce0 || (s_valid && s_ready)) begin
                    check("b0_ce_on_beat", b0_ce0, s_valid && s_ready);
                    check("b0_we0", b0_we0, 1);
                    if (wr_idx < s_total) begin
                        check("b0_addr0", b0_addr0, wr_idx);
                        check("b0_d0", b0_d0, in_data[wr_idx]);
                    end else begin
                        check("b0_extra_write", wr_idx, s_total - 1);
                    end
                    wr_idx++;
                end
                if (core_en) begin
                    pulses++;
                    check("core_en_idle", core_idle, 1);
                    check("core_en_run", core_run, ld_run);
                    check("core_en_num", core_num_cnt, ld_n - 1);
                end
                if (prev_stall) check("m_valid_hold", m_valid, 1);
                if (m_valid) begin
                    if (out_idx < cur_m) begin
                        if (!seen_first) begin
                            seen_first = 1;
                            first_cyc  = cyc;
                        end
                        check("m_data", m_data, exp_data[out_idx]);
                        check("m_last", m_last, out_idx == cur_m - 1);
                        if (m_ready) begin
                            if (out_idx == cur_m - 1) last_cyc = cyc;
                            out_idx++;
                        end
                    end else begin
                        check("m_extra_beat", out_idx, cur_m - 1);
                    end
                end
                prev_stall = m_valid && !m_ready;
            end
        end
    end

    task automatic prep_load(input bit run, input int n, input int m);
        for (int i = 0; i < n; i++) in_data[i] = DW'($urandom);
        s_idx   = 0;
        wr_idx  = 0;
        s_total = n;
        ld_run  = run;
        ld_n    = n;
        ld_m    = m;
    endtask

    task automatic prep_drain();
        cur_m = ld_m;
        for (int i = 0; i < ld_m; i++)
            exp_data[i] = ld_run ? xform(in_data[i]) : in_data[i];
        out_idx    = 0;
        pulses     = 0;
        seen_first = 0;
    endtask

    task automatic send_cmd(input bit run, input int n, input int m);
        int c = 0;
        @(posedge clk); #1;
        cmd_run     = run;
        cmd_num_cnt = AW'(n);
        cmd_out_cnt = AW'(m);
        cmd_valid   = 1'b1;
        do begin sample(); c++; end while (!cmd_ready && c < 1000);
        check("cmd_ready_wait", c < 1000, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        sample();
        check("busy_after_cmd", busy, (n > 0) && (m > 0));
    endtask

    task automatic start_frame(input bit run, input int n, input int m, input bit gaps, input bit rr);
        @(posedge clk); #2;
        prep_load(run, n, m);
        prep_drain();
        s_gaps = gaps;
        r_rand = rr;
        send_cmd(run, n, m);
    endtask

    task automatic wait_mvalid();
        int c = 0;
        do begin sample(); c++; end while (!m_valid && c < 5000);
        check("m_valid_wait", c < 5000, 1);
    endtask

    task automatic finish_frame(input bit pulse);
        int  c = 0;
        int  budget;
        bit  pl = 0, pd = 0;
        budget = 8 * (ld_n + ld_m) + 500;
        do begin
            sample();
            c++;
            if (pulse && ((s_ready && !pl) || (m_valid && !pd))) begin
                if (s_ready) pl = 1; else pd = 1;
                check("cmd_ready_busy", cmd_ready, 0);
                @(posedge clk); #1;
                cmd_valid   = 1'b1;
                cmd_run     = ~ld_run;
                cmd_num_cnt = AW'(5);
                cmd_out_cnt = AW'(3);
                @(posedge clk); #1;
                cmd_valid = 1'b0;
                c += 2;
            end
        end while (!(out_idx == cur_m && !busy) && c < budget);
        check("frame_done_wait", c < budget, 1);
        exp_frames++;
        check("frame_cnt", frame_cnt, exp_frames);
        check("frame_writes", wr_idx, ld_n);
        check("frame_beats", out_idx, cur_m);
        check("frame_pulses", pulses, 1);
        if (pulse) begin
            repeat (3) begin
                sample();
                check("no_phantom_frame", busy, 0);
            end
        end
    endtask

    initial begin : main
        int n, m;
        cmd_valid   = 1'b0;
        cmd_run     = 1'b0;
        cmd_num_cnt = '0;
        cmd_out_cnt = '0;
        core_idle   = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_core_en", core_en, 0);
        check("rst_core_num", core_num_cnt, 0);
        check("rst_b0_ce0", b0_ce0, 0);
        check("rst_b1_ce0", b1_ce0, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("cmd_ready_before_edge", cmd_ready, 0);
        @(posedge clk); #1;
        check("cmd_ready_after_rst", cmd_ready, 1);

        // MOVE 16/16, no gaps, full throughput.
        start_frame(0, 16, 16, 0, 0);
        finish_frame(0);
        check("move_throughput", last_cyc - first_cyc + 1, 16);

        // Zero counts are accepted and dropped.
        send_cmd(1, 0, 10);
        check("drop_n0_ready", cmd_ready, 1);
        send_cmd(0, 10, 0);
        check("drop_m0_ready", cmd_ready, 1);
        check("drop_frame_cnt", frame_cnt, exp_frames);

        // RUN frame, 100x100 in, 98x98 out.
        start_frame(1, 10000, 9604, 0, 0);
        finish_frame(0);
        check("run_throughput", last_cyc - first_cyc + 1, 9604);

        // Minimal frame.
        start_frame(1, 1, 1, 1, 1);
        finish_frame(0);

        // Random frames with input gaps and random backpressure.
        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(1, 300);
            m = $urandom_range(1, n);
            start_frame(1'($urandom_range(0, 1)), n, m, 1, 1);
            finish_frame(0);
        end

        // Commands pulsed during LOAD and DRAIN are ignored.
        start_frame(0, 40, 30, 1, 1);
        finish_frame(1);

        // Command held from DRAIN is accepted on the first IDLE cycle.
        start_frame(1, 50, 50, 0, 1);
        wait_mvalid();
        @(posedge clk); #2;
        n = $urandom_range(5, 60);
        m = $urandom_range(1, n);
        begin : held
            int c = 0;
            int a_m;
            a_m = cur_m;
            prep_load(0, n, m);
            cmd_run     = 1'b0;
            cmd_num_cnt = AW'(n);
            cmd_out_cnt = AW'(m);
            cmd_valid   = 1'b1;
            do begin sample(); c++; end while (!cmd_ready && c < 2000);
            check("held_wait", c < 2000, 1);
            check("held_first_idle", busy, 0);
            check("held_a_beats", out_idx, a_m);
            check("held_a_pulses", pulses, 1);
            exp_frames++;
            check("held_a_frame_cnt", frame_cnt, exp_frames);
            prep_drain();
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            sample();
            check("held_accepted", busy, 1);
        end
        finish_frame(0);

        // core_idle low for 10 cycles in START.
        core_idle = 1'b0;
        start_frame(0, 20, 20, 0, 0);
        begin : idle_wait
            int c = 0;
            while (wr_idx < ld_n && c < 1000) begin sample(); c++; end
            check("load_wait", c < 1000, 1);
            repeat (10) begin
                sample();
                check("core_en_while_busy_core", core_en, 0);
            end
            check("no_pulse_yet", pulses, 0);
            @(posedge clk); #1;
            core_idle = 1'b1;
            sample();
            check("core_en_on_idle", core_en, 1);
        end
        finish_frame(0);

        // Reset in the middle of DRAIN.
        start_frame(0, 200, 200, 0, 1);
        wait_mvalid();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_m_data", m_data, 0);
        check("mid_rst_b1_ce0", b1_ce0, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cmd_ready", cmd_ready, 0);
        check("mid_rst_frame_cnt", frame_cnt, 0);
        s_total = 0;
        exp_frames = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        start_frame(1, 30, 25, 1, 1);
        finish_frame(0);

        check("err_default_build", err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the bench always ends.
    initial begin : watchdog
        #5ms;
        $display("FAIL global_timeout: simulation exceeded time limit");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sobel_frame_scheduler.md
Name: sobel_frame_scheduler

Overview:
Frame-level sequencer wrapped around the Sobel read/write core and its two BRAMs. It accepts one frame command at a time and streams input pixels into BRAM0 through port 0. It then starts the core in either MOVE mode (plain copy) or RUN mode (Sobel) and waits for completion. Finally it drains BRAM1 through port 0 as an output stream with backpressure, and returns to idle ready for the next frame.

Parameters:
DATA_WIDTH, 8, pixel width
ADDR_WIDTH, 12, BRAM address width
TIMEOUT_CYCLES, 65535, PROC watchdog limit (used only with the optional feature)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
cmd_valid  in  1  frame command valid
cmd_ready  out  1  scheduler can accept a command (IDLE only)
cmd_run  in  1  1 = Sobel RUN, 0 = MOVE
cmd_num_cnt  in  ADDR_WIDTH  input pixel count N (1..2^ADDR_WIDTH-1)
cmd_out_cnt  in  ADDR_WIDTH  output pixel count M to drain (1..2^ADDR_WIDTH-1)
s_valid / s_ready / s_data  in/out/in  1/1/DATA_WIDTH  input pixel stream
core_en  out  1  one-cycle start pulse to the core
core_run  out  1  mode to the core; held from START through PROC
core_num_cnt  out  ADDR_WIDTH  N-1; held from START through PROC
core_idle  in  1  core idle status
core_done  in  1  core done (single cycle)
b0_ce0 / b0_we0 / b0_addr0 / b0_d0  out  1/1/ADDR_WIDTH/DATA_WIDTH  BRAM0 port 0 write side
b1_ce0 / b1_we0 / b1_addr0  out  1/1/ADDR_WIDTH  BRAM1 port 0 read side
b1_q0  in  DATA_WIDTH  BRAM1 read data; valid 1 cycle after ce
m_valid / m_ready / m_data / m_last  out/in/out/out  1/1/DATA_WIDTH/1  output pixel stream
busy  out  1  state != IDLE
frame_cnt  out  16  completed frames; wraps at 65535 -> 0
err  out  1  sticky error flag (used only with the optional feature)

Behaviour:
- Reset values: all outputs 0, including cmd_ready, frame_cnt and err. State IDLE; counters cleared. The first cycle after reset release drives cmd_ready=1.
- States: IDLE, LOAD, START, PROC, DRAIN.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch run, N and M; clear the load address; go to LOAD.
  - A command with N=0 or M=0 is accepted and dropped; the state stays IDLE.
- LOAD:
  - s_ready=1.
  - Each s_valid&&s_ready beat writes BRAM0: ce=we=1, addr=load address, d=s_data, all in the same cycle. The load address then increments.
  - When the beat at address N-1 is written, go to START on the next cycle. s_ready drops in that cycle.
- START:
  - Wait for core_idle=1.
  - In the cycle where core_idle=1, assert core_en for exactly 1 cycle, then go to PROC.
- PROC:
  - Wait for core_done.
  - On core_done, go to DRAIN and clear the read and output counters.
- DRAIN:
  - Issue a BRAM1 read (ce=1, we=0 always) only when the 2-entry output skid buffer has room accounting for the in-flight read. This guarantees no data loss under any m_ready pattern.
  - Reads cover addresses 0..M-1 in order. Read data is captured 1 cycle after issue.
  - m_valid is held until m_ready; m_data and m_last stay stable while m_valid&&!m_ready.
  - m_last=1 on output beat M-1 only.
  - When beat M-1 is accepted, return to IDLE and increment frame_cnt (same cycle).
- Throughput: with m_ready held at 1, DRAIN delivers 1 beat per cycle after 1 cycle of read latency.
- Port exclusivity: BRAM0 port 0 is never enabled outside LOAD; BRAM1 port 0 is never enabled outside DRAIN.
- Commands are not queued: cmd_valid outside IDLE is ignored (cmd_ready=0).
- Reset mid-frame: all state is discarded immediately; the partial frame is lost; frame_cnt returns to 0.

Optional Feature:
- Macro SOBEL_SCHED_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counts cycles spent in PROC.
  - If it reaches TIMEOUT_CYCLES without core_done: set err (sticky until reset), skip DRAIN, return to IDLE.
  - frame_cnt is not incremented on a timeout.
- Undefined: no watchdog; err is tied to 0; PROC waits indefinitely.

Test Plan:
- MOVE frame, N=16, M=16, s_valid and m_ready held high (core model copies): BRAM0 gets addresses 0..15 with the input data; core_en pulses once with core_num_cnt=15 and core_run=0; 16 output beats match the input; m_last on beat 15; frame_cnt=1.
- RUN frame, N=100*100, M=98*98: core_run=1 through PROC; exactly 9604 beats; m_last on the last beat only.
- Random s_valid gaps and random m_ready (50%): no lost or duplicated beats; m_data stable while stalled; output order preserved.
- cmd_valid pulsed during LOAD and DRAIN: not accepted; a command held until IDLE is accepted on the first IDLE cycle.
- core_idle held at 0 for 10 cycles in START: core_en stays low, then pulses in the first cycle core_idle=1.
- Reset asserted mid-DRAIN: all outputs 0 asynchronously; the next command runs a clean frame.
- With SOBEL_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=50, core_done never asserted: err=1 after 50 PROC cycles; state returns to IDLE; frame_cnt is unchanged.
